// File: rtl/demux_pkg.sv
// Shared types for the demux route sequencer: FSM states, destination codes
// and the request record stored in the route FIFO.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAPW
    } route_state_t;

    typedef logic [1:0] dest_t;

    typedef struct packed {
        logic  data;
        dest_t dest;
    } route_req_t;

    localparam dest_t DEST_O1 = 2'd0;
    localparam dest_t DEST_O2 = 2'd1;
    localparam dest_t DEST_O3 = 2'd2;
    localparam dest_t DEST_O4 = 2'd3;

endpackage

// File: rtl/demux_route_seq_if.sv
// Request channel into the sequencer plus the A/S1/S2 bus it drives toward the demux.
interface demux_route_seq_if;
    import demux_pkg::*;

    // Handshake: a request transfers on every rising edge where in_valid && in_ready.
    // The master holds in_data/in_dest stable while in_valid is high and not yet accepted;
    // in_ready does not depend on in_valid.
    logic  in_valid;
    logic  in_ready;
    logic  in_data;
    dest_t in_dest;
    logic  A;
    logic  S1;
    logic  S2;

    modport master (
        output in_valid,
        output in_data,
        output in_dest,
        input  in_ready,
        input  A,
        input  S1,
        input  S2
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dest,
        output in_ready,
        output A,
        output S1,
        output S2
    );

endinterface

// File: rtl/demux.sv
// Combinational 1:4 demultiplexer: A is steered to O1..O4 by {S2,S1}.
module demux (
    input  logic A,
    input  logic S1,
    input  logic S2,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4
);

    assign O1 = A & ~S2 & ~S1;
    assign O2 = A & ~S2 &  S1;
    assign O3 = A &  S2 & ~S1;
    assign O4 = A &  S2 &  S1;

endmodule

// File: rtl/route_fifo.sv
// Synchronous FIFO of route requests; full/empty are derived from the occupancy count.
module route_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  route_req_t               wdata_i,
    output route_req_t               rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    route_req_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push_i && (level_q != FULL_LVL);
    assign pop_ok  = pop_i && (level_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in level_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/demux_route_seq.sv
// Buffers routing requests and drives A/S1/S2 for HOLD cycles per route, then GAP idle
// cycles, so the selects never move while a destination is being driven.
module demux_route_seq
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    demux_route_seq_if.slave         bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output route_state_t             dbg_state_o
);

    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = (GAP > 0) ? CW'(GAP - 1) : '0;

    route_state_t    state_q;
    logic [CW-1:0]   cnt_q;
    logic            a_q;
    logic            s1_q;
    logic            s2_q;
    logic            busy_q;

    route_req_t      req;
    route_req_t      head;
    logic [LW-1:0]   fifo_level;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign req          = '{data: bus.in_data, dest: bus.in_dest};
    assign fifo_empty   = (fifo_level == '0);
    assign bus.in_ready = rst_n && (fifo_level != FULL_LVL);
    assign push         = bus.in_valid && bus.in_ready;

    route_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (req),
        .rdata_o (head),
        .level_o (fifo_level)
    );

    // A pop is exactly the edge that loads a new route into DRIVE.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                IDLE:    pop = 1'b1;
                DRIVE:   pop = (cnt_q == '0) && (GAP == 0);
                GAPW:    pop = (cnt_q == '0);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= DRIVE;
            cnt_q   <= HOLD_LD;
            a_q     <= head.data;
            s1_q    <= head.dest[0];
            s2_q    <= head.dest[1];
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (GAP > 0) begin
                        state_q <= GAPW;
                        cnt_q   <= GAP_LD;
                        a_q     <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        a_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                GAPW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    a_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A       = a_q;
    assign bus.S1      = s1_q;
    assign bus.S2      = s2_q;
    assign busy        = busy_q;
    assign level       = fifo_level;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_demux_route_seq.sv
// End-to-end bench: sequencer feeding the 1:4 demux, plus a GAP=0 sequencer instance.
module tb_demux_route_seq;
    import demux_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;

    demux_route_seq_if bus ();
    demux_route_seq_if bus0 ();

    logic          busy, busy0;
    logic [LW-1:0] level, level0;
    route_state_t  dbg_state, dbg_state0;
    logic          o1, o2, o3, o4;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    bit         mon_en;
    bit         in_run, gap_track;
    int         run_len, gap_len;
    logic [1:0] run_sel;
    int         max_lvl;
    bit         stall_seen;
    logic [1:0] r0d [3];

    demux_route_seq #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .level       (level),
        .dbg_state_o (dbg_state)
    );

    demux u_demux (
        .A  (bus.A),
        .S1 (bus.S1),
        .S2 (bus.S2),
        .O1 (o1),
        .O2 (o2),
        .O3 (o3),
        .O4 (o4)
    );

    demux_route_seq #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus0),
        .busy        (busy0),
        .level       (level0),
        .dbg_state_o (dbg_state0)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic [1:0] dst);
        int waited = 0;
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dest  = dst;
        while (!done && waited < 50) begin
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (bus.in_ready) done = 1'b1;
            else stall_seen = 1'b1;
            tick();
            waited++;
        end
        bus.in_valid = 1'b0;
        check_val("push_accept", done, 1);
        if (d && mon_en) exp_q.push_back(dst);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || level != '0) && n < budget) begin
            tick();
            n++;
        end
        check_val("idle_reached", {busy, (level != '0)}, 0);
    endtask

    // Scoreboard: every A=1 run must match the oldest queued destination.
    always @(negedge clk) begin
        logic [3:0] exp_oh;
        if (!mon_en) begin
            in_run    = 1'b0;
            gap_track = 1'b0;
            run_len   = 0;
            gap_len   = 0;
        end else if (bus.A) begin
            if (!in_run) begin
                check_val("sb_nonempty", (exp_q.size() != 0), 1);
                if (gap_track) check_val("gap_len", gap_len, GAP);
                in_run    = 1'b1;
                gap_track = 1'b0;
                run_len   = 0;
                run_sel   = {bus.S2, bus.S1};
            end
            run_len++;
            if (run_len > 1) check_val("sel_stable", {bus.S2, bus.S1}, run_sel);
            exp_oh = 4'b0000;
            if (exp_q.size() != 0) exp_oh = 4'b0001 << exp_q[0];
            check_val("demux_out", {o4, o3, o2, o1}, exp_oh);
        end else begin
            check_val("demux_idle", {o4, o3, o2, o1}, 0);
            if (in_run) begin
                check_val("hold_len", run_len, HOLD);
                if (exp_q.size() != 0) begin
                    check_val("route_dest", run_sel, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                in_run    = 1'b0;
                gap_track = 1'b1;
                gap_len   = 0;
            end
            if (gap_track) begin
                if (busy) gap_len++;
                else gap_track = 1'b0;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 1'b0;
        bus.in_dest   = 2'd0;
        bus0.in_valid = 1'b0;
        bus0.in_data  = 1'b0;
        bus0.in_dest  = 2'd0;
        mon_en        = 1'b1;
        max_lvl       = 0;
        stall_seen    = 1'b0;
        r0d[0] = DEST_O4;
        r0d[1] = DEST_O1;
        r0d[2] = DEST_O3;

        // Reset values
        repeat (2) tick();
        check_val("rst_A", bus.A, 0);
        check_val("rst_sel", {bus.S2, bus.S1}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_level", level, 0);
        check_val("rst_ready", bus.in_ready, 0);
        check_val("rst_state", dbg_state, IDLE);
        check_val("rst_busy0", busy0, 0);
        rst_n = 1'b1;
        tick();
        check_val("ready_after_rst", bus.in_ready, 1);

        // Single request data=1 dest=2: latency, hold, gap, selects retained
        push(1'b1, DEST_O3);
        check_val("t1_level", level, 1);
        check_val("t1_A_pre", bus.A, 0);
        check_val("t1_busy_pre", busy, 0);
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check_val("t1_A", bus.A, 1);
            check_val("t1_sel", {bus.S2, bus.S1}, 2'b10);
            check_val("t1_O3", o3, 1);
            check_val("t1_busy", busy, 1);
        end
        tick();
        check_val("t1_gap_A", bus.A, 0);
        check_val("t1_gap_busy", busy, 1);
        check_val("t1_gap_sel", {bus.S2, bus.S1}, 2'b10);
        tick();
        check_val("t1_idle_busy", busy, 0);
        check_val("t1_idle_sel", {bus.S2, bus.S1}, 2'b10);
        check_val("t1_idle_state", dbg_state, IDLE);

        // Burst of all four destinations in order
        for (int i = 0; i < 4; i++) push(1'b1, 2'(i));
        check_val("t2_level", level, 3);
        check_val("t2_busy", busy, 1);
        wait_idle(200);

        // Fill the FIFO while driving; 12 pushes wrap the pointers
        max_lvl    = 0;
        stall_seen = 1'b0;
        for (int i = 0; i < 12; i++) push(1'b1, 2'((i * 3) % 4));
        check_val("t3_max_level", max_lvl, DEPTH);
        check_val("t3_stalled", stall_seen, 1);
        wait_idle(200);

        // GAP=0 instance: contiguous routes, reload with no idle cycle
        check_val("t4_ready", bus0.in_ready, 1);
        for (int k = 0; k < 14; k++) begin
            if (k < 3) begin
                bus0.in_valid = 1'b1;
                bus0.in_data  = 1'b1;
                bus0.in_dest  = r0d[k];
            end else begin
                bus0.in_valid = 1'b0;
            end
            tick();
            if (k == 0) begin
                check_val("t4_A_pre", bus0.A, 0);
                check_val("t4_busy_pre", busy0, 0);
            end else if (k <= 12) begin
                check_val("t4_A", bus0.A, 1);
                check_val("t4_busy", busy0, 1);
                check_val("t4_sel", {bus0.S2, bus0.S1}, r0d[(k - 1) / 4]);
            end else begin
                check_val("t4_A_end", bus0.A, 0);
                check_val("t4_busy_end", busy0, 0);
                check_val("t4_sel_end", {bus0.S2, bus0.S1}, r0d[2]);
            end
        end
        check_val("t4_state", dbg_state0, IDLE);
        check_val("t4_level", level0, 0);

        // Reset in the middle of DRIVE with two entries queued
        mon_en = 1'b0;
        push(1'b1, DEST_O2);
        push(1'b1, DEST_O3);
        push(1'b1, DEST_O4);
        check_val("t5_pre_level", level, 2);
        check_val("t5_pre_A", bus.A, 1);
        check_val("t5_pre_state", dbg_state, DRIVE);
        rst_n = 1'b0;
        tick();
        check_val("t5_A", bus.A, 0);
        check_val("t5_sel", {bus.S2, bus.S1}, 0);
        check_val("t5_level", level, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        tick();
        check_val("t5_post_busy", busy, 0);
        check_val("t5_post_level", level, 0);
        mon_en = 1'b1;
        push(1'b1, DEST_O4);
        wait_idle(200);

        // data=0 to dest=3: selects move, outputs stay low
        push(1'b0, DEST_O4);
        check_val("t6_level", level, 1);
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check_val("t6_A", bus.A, 0);
            check_val("t6_sel", {bus.S2, bus.S1}, 2'b11);
            check_val("t6_busy", busy, 1);
            check_val("t6_outs", {o4, o3, o2, o1}, 0);
        end
        tick();
        check_val("t6_gap_busy", busy, 1);
        tick();
        check_val("t6_idle_busy", busy, 0);
        wait_idle(50);

        check_val("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_route_seq.md
# demux_route_seq

Upstream sequencer for the 1:4 `demux` stage. It accepts routing requests of one data bit plus a 2-bit destination over a valid/ready handshake, and buffers them in a small FIFO. It then drives the demux inputs `A`, `S1` and `S2`, holding each route for a fixed number of cycles with an optional idle gap between routes. This ensures the demux select lines never change while a destination is being driven.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD`, 4: cycles each route is driven; ≥1.
- `GAP`, 1: idle cycles after each route (`A`=0, selects held); ≥0.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept; equals `level != DEPTH`; forced 0 while `rst_n`=0.
- `in_data` in 1: bit to route.
- `in_dest` in 2: destination 0..3, mapping to O1..O4.
- `A` out 1: demux data input, registered.
- `S1` out 1: demux select LSB (`in_dest[0]`), registered.
- `S2` out 1: demux select MSB (`in_dest[1]`), registered.
- `busy` out 1: FSM not in IDLE, registered.
- `level` out $clog2(DEPTH)+1: FIFO occupancy; excludes the route currently being driven.

## Operation
- A push occurs when `in_valid && in_ready`. The FIFO has no bypass: the FSM pops only entries already stored.
- FSM states: IDLE, DRIVE, GAPW. There is one down-counter, `cnt`, of width $clog2(max(HOLD,GAP,1))+1.
- IDLE: `A`=0, `S1`/`S2` hold their last values. If the FIFO is non-empty, pop, load `A`=data, `{S2,S1}`=dest, set `cnt`=HOLD-1, and go to DRIVE.
- DRIVE: outputs are held. If `cnt`≠0, decrement. If `cnt`=0:
  - GAP>0: set `A`=0, `cnt`=GAP-1, go to GAPW.
  - GAP=0 and FIFO non-empty: pop and reload directly, staying in DRIVE.
  - Otherwise: set `A`=0 and go to IDLE.
- GAPW: `A`=0, selects held. If `cnt`≠0, decrement. If `cnt`=0: if the FIFO is non-empty, pop and load into DRIVE; otherwise go to IDLE.
- `S1`/`S2` change only on the same edge that loads a new route. `A` is 0 whenever the FSM is not in DRIVE.
- Full FIFO: `in_ready`=0, so no push. A pop on edge E raises `in_ready` after E.
- Push and pop in the same cycle: `level` is unchanged and the pointers both advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `level`.

## Timing
- Reset values: `A`=0, `S1`=0, `S2`=0, `busy`=0, `level`=0, state=IDLE, `cnt`=0, pointers=0. FIFO contents are don't-care.
- Reset mid-route drops the active route and all queued entries. Outputs reach reset values on the first edge with `rst_n`=0.
- Latency, empty and idle: a request accepted on edge E is stored at E. It is popped at E+1, and outputs show it after E+1.
- Each route holds `A`/`S*` for exactly HOLD cycles, followed by exactly GAP cycles with `A`=0.
- Sustained throughput is one request per HOLD+GAP cycles.
- `busy` is 1 from the load edge through the last DRIVE/GAPW cycle.

## Structure
- Package `demux_pkg`:
  - `typedef enum {IDLE, DRIVE, GAPW} route_state_t`
  - `typedef logic [1:0] dest_t`
  - `typedef struct packed {logic data; dest_t dest;} route_req_t`
  - `localparam dest_t DEST_O1=0, DEST_O2=1, DEST_O3=2, DEST_O4=3`
- One sub-module, `route_fifo`: a synchronous FIFO of `route_req_t`, parameterised by DEPTH, with push/pop/level outputs. The FSM and output registers live in the top level.
- The bench instantiates `demux_route_seq` feeding `demux` and checks O1..O4 end to end.

## Test plan
- Reset, then one request (data=1, dest=2), HOLD=4, GAP=1: after the accept edge plus one, `S2`=1, `S1`=0, `A`=1 for 4 cycles, so O3=1 for 4 cycles. Then `A`=0 for 1 cycle, then IDLE with `S2`/`S1` still 1/0.
- Burst of all four dests with data=1, in order 0..3: O1..O4 each pulse for exactly HOLD cycles, in order, with GAP idle cycles between. Selects never change while `A`=1.
- Fill the FIFO (DEPTH=4) while the FSM is in DRIVE: `level` reaches 4 and `in_ready`=0. `in_valid` held high stalls until the next pop. No request is lost or duplicated across 12 pushes, so pointer wrap is exercised.
- GAP=0, back-to-back requests: routes are contiguous, `busy` stays 1, and the reload happens on the `cnt`=0 edge with no IDLE cycle.
- Assert `rst_n`=0 for 1 cycle in the middle of DRIVE with 2 entries queued: the next cycle shows `A`/`S1`/`S2`=0, `level`=0, `busy`=0. After release, a new request routes normally.
- Data=0 request to dest=3: `S2`=`S1`=1 for HOLD cycles with `A`=0, and O1..O4 all stay 0.
